bcp_ucq: RTL and testbench
==========================

# bcp_ucq

Unit-clause queue (UCQ) for the BCP engine. It buffers implied and decided literals between the PE array's implication outputs and the PE's unit-clause input. It drops duplicate literals and detects contradictory literals (x and -x both pending), raising a sticky conflict. One instance sits per BCP engine: writes come from the PE implication path and the decision logic, reads go to the PE `litDec`/`UCQ_out_pop` handshake.

## Interface
Parameters:
- `DEPTH`, 16: entry count; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-high reset; the port name follows codebase convention, the polarity is high.
- `flush`  in  1  synchronous clear on backtrack/restart.
- `push`  in  1  write request.
- `push_lit`  in  `lit_t`  literal to enqueue; two's-complement, 0 means none.
- `pop`  in  1  consume head (from PE `UCQ_out_pop`).
- `pop_lit`  out  `lit_t`  head literal; valid while `empty`=0, 0 when empty.
- `empty`  out  1  no valid entries (to PE `UCQ_out_empty`).
- `full`  out  1  count == DEPTH (to PE `UCQ_in_full`).
- `count`  out  $clog2(DEPTH+1)  occupancy.
- `conflict`  out  1  sticky; contradiction detected since last flush/reset.
- `dup_drop`  out  1  one-cycle pulse; last accepted-cycle push was a duplicate.
- `overflow`  out  1  sticky; push attempted while full without a same-cycle pop.

## Operation
- Storage is a circular buffer with `DEPTH` slots, each holding a literal and a valid bit, plus head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- Match check is combinational against every valid slot in the pre-update state, including the slot being popped in the same cycle.
- Priority order for each push:
  1. `push_lit`==0 or `push_lit`==most-negative `lit_t`: ignored. No flags change.
  2. `conflict` already set: push is dropped silently.
  3. Any valid slot equals -`push_lit`: `conflict` is set and the push is dropped.
  4. Any valid slot equals `push_lit`: the push is dropped and `dup_drop` pulses.
  5. `full` and no `pop` this cycle: the push is dropped and `overflow` is set.
  6. Otherwise the literal is written at the tail, the slot is marked valid, and the tail advances.
- Pop:
  - When `empty`=0, `pop` clears the head valid bit and advances the head.
  - When empty, `pop` is ignored.
  - Pops remain allowed while `conflict` is set.
- Simultaneous push and pop: both take effect and `count` is unchanged. A push while full is accepted if `pop` is asserted in the same cycle.
- `flush` overrides push and pop in its cycle. It clears all valid bits, both pointers, `count`, `conflict`, `overflow` and `dup_drop`.
- Reset values: both pointers 0, all valid bits 0, `count`=0, `empty`=1, `full`=0, `pop_lit`=0, `conflict`=0, `overflow`=0, `dup_drop`=0.

## Timing
- All flags and `count` are registered. `pop_lit` is a mux of the head slot, so it changes only after clock edges.
- Push-to-visible latency is 1 cycle. A push into an empty queue at edge N gives `empty`=0 and `pop_lit`=literal after edge N.
- Pop takes effect at the edge. The next head appears after that edge.
- `conflict`, `overflow` and `dup_drop` update at the edge ending the offending cycle. `dup_drop` lasts exactly one cycle.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The first push is accepted at the first edge after reset deasserts.

## Structure
- Shared package `bcp_pkg` holds `lit_t`, `LIT_IDX_MAX`, `CLA_LENGTH` and `LIT_W` ($clog2(LIT_IDX_MAX)+1).
- Sub-module `bcp_ucq_match` is a purely combinational comparator array. It takes slot literals, valid bits and the query literal, and returns `hit_same` and `hit_neg`.
- Top level holds the pointers, count, flags and write/pop control.

## Test plan
- Push 5, 7, -3 in consecutive cycles, then pop 3 times → `pop_lit` reads 5, 7, -3. `empty`=1 and `count`=0 at the end.
- Push 4, then push 4 → second push is dropped. `dup_drop` pulses once and `count` stays 1.
- Push 6, then push -6 → `conflict`=1 and `count`=1. A later push of 9 is dropped and `pop_lit` is still 6. After `flush`, `conflict`=0, `empty`=1, and a push of -6 is accepted.
- DEPTH=16:
  - Fill with literals 1..16 → `full`=1.
  - Push 17 without pop → `overflow`=1 and the push is dropped.
  - Push 17 with pop → head becomes 2 and `count` stays 16.
  - Drain → order is 2..17, confirming pointer wrap.
- Head is 8. In the same cycle, pop and push -8 → `conflict`=1 because the pre-pop state is used, and the queue becomes empty.
- Assert `rst_n` asynchronously mid-fill, between clock edges → all outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared BCP literal types and sizing constants
package bcp_pkg;

  localparam int LIT_IDX_MAX = 255;
  localparam int CLA_LENGTH  = 8;
  localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;

  typedef logic signed [LIT_W-1:0] lit_t;

  // Most-negative code has no valid negation, so it is treated like "no literal".
  localparam lit_t LIT_MIN = {1'b1, {(LIT_W-1){1'b0}}};

  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

  function automatic logic lit_is_real(input lit_t l);
    return (l != '0) && (l != LIT_MIN);
  endfunction

endpackage

// File: rtl/bcp_ucq_if.sv
// rtl/bcp_ucq_if.sv - push/pop handshake and status bundle of the unit-clause queue
interface bcp_ucq_if #(
  parameter int DEPTH = 16
);
  import bcp_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          push;
  lit_t          push_lit;
  logic          pop;
  lit_t          pop_lit;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          conflict;
  logic          dup_drop;
  logic          overflow;

  modport master (
    output flush, push, push_lit, pop,
    input  pop_lit, empty, full, count, conflict, dup_drop, overflow
  );

  modport slave (
    input  flush, push, push_lit, pop,
    output pop_lit, empty, full, count, conflict, dup_drop, overflow
  );

endinterface

// File: rtl/bcp_ucq_match.sv
// rtl/bcp_ucq_match.sv - combinational same/negated literal match across all valid slots
module bcp_ucq_match
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  lit_t             slot_lit [DEPTH],
  input  logic [DEPTH-1:0] slot_vld,
  input  lit_t             query,
  output logic             hit_same,
  output logic             hit_neg
);

  lit_t query_neg;

  always_comb begin
    query_neg = lit_neg(query);
    hit_same  = 1'b0;
    hit_neg   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && (slot_lit[i] == query))     hit_same = 1'b1;
      if (slot_vld[i] && (slot_lit[i] == query_neg)) hit_neg  = 1'b1;
    end
  end

endmodule

// File: rtl/bcp_ucq.sv
// rtl/bcp_ucq.sv - unit-clause queue: circular literal buffer with duplicate drop
// and sticky contradiction/overflow detection
module bcp_ucq
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  bcp_ucq_if.slave  q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  lit_t             lit_q [DEPTH];
  lit_t             lit_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             conflict_q, conflict_d;
  logic             overflow_q, overflow_d;
  logic             dup_q, dup_d;

  logic             hit_same, hit_neg;
  logic             push_ok, pop_en, wr_en;

  // Match runs on the pre-update slots, so a slot being popped this cycle still counts.
  bcp_ucq_match #(.DEPTH(DEPTH)) u_match (
    .slot_lit (lit_q),
    .slot_vld (vld_q),
    .query    (q.push_lit),
    .hit_same (hit_same),
    .hit_neg  (hit_neg)
  );

  assign push_ok = q.push && lit_is_real(q.push_lit);
  assign pop_en  = q.pop && !empty_q;

  always_comb begin
    lit_d      = lit_q;
    vld_d      = vld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    empty_d    = empty_q;
    full_d     = full_q;
    conflict_d = conflict_q;
    overflow_d = overflow_q;
    dup_d      = 1'b0;
    wr_en      = 1'b0;

    if (q.flush) begin
      vld_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      empty_d    = 1'b1;
      full_d     = 1'b0;
      conflict_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok && !conflict_q) begin
        if (hit_neg)                conflict_d = 1'b1;
        else if (hit_same)          dup_d      = 1'b1;
        else if (full_q && !q.pop)  overflow_d = 1'b1;
        else                        wr_en      = 1'b1;
      end

      // Pop clears before the write sets, so full push+pop on the same slot keeps it valid.
      if (pop_en) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + 1'b1;
      end
      if (wr_en) begin
        lit_d[tail_q] = q.push_lit;
        vld_d[tail_q] = 1'b1;
        tail_d        = tail_q + 1'b1;
      end

      count_d = count_q + CW'(wr_en) - CW'(pop_en);
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) lit_q[i] <= '0;
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
      dup_q      <= 1'b0;
    end else begin
      lit_q      <= lit_d;
      vld_q      <= vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      conflict_q <= conflict_d;
      overflow_q <= overflow_d;
      dup_q      <= dup_d;
    end
  end

  assign q.pop_lit  = vld_q[head_q] ? lit_q[head_q] : '0;
  assign q.empty    = empty_q;
  assign q.full     = full_q;
  assign q.count    = count_q;
  assign q.conflict = conflict_q;
  assign q.overflow = overflow_q;
  assign q.dup_drop = dup_q;

endmodule

// File: tb/tb_bcp_ucq.sv
// tb/tb_bcp_ucq.sv - randomized and directed self-checking bench for bcp_ucq
module tb_bcp_ucq;
  import bcp_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   cmp_en;

  int   m_q[$];
  bit   m_conflict;
  bit   m_overflow;
  bit   m_dup;

  bcp_ucq_if #(.DEPTH(DEPTH)) u_if ();

  bcp_ucq #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_conflict = 1'b0;
    m_overflow = 1'b0;
    m_dup      = 1'b0;
  endfunction

  function automatic bit model_has(input int v);
    foreach (m_q[i]) if (m_q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input bit p, input int l, input bit po, input bit f);
    bit wr;
    bit do_pop;
    if (f) begin
      model_reset();
      return;
    end
    wr     = 1'b0;
    do_pop = po && (m_q.size() > 0);
    m_dup  = 1'b0;
    if (p && l != 0 && l != -256 && !m_conflict) begin
      if (model_has(-l))                         m_conflict = 1'b1;
      else if (model_has(l))                     m_dup      = 1'b1;
      else if (m_q.size() == DEPTH && !po)       m_overflow = 1'b1;
      else                                       wr         = 1'b1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (wr) m_q.push_back(l);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_count",    int'(u_if.count),    m_q.size());
      chk("cmp_empty",    int'(u_if.empty),    int'(m_q.size() == 0));
      chk("cmp_full",     int'(u_if.full),     int'(m_q.size() == DEPTH));
      chk("cmp_pop_lit",  int'(u_if.pop_lit),  (m_q.size() > 0) ? m_q[0] : 0);
      chk("cmp_conflict", int'(u_if.conflict), int'(m_conflict));
      chk("cmp_overflow", int'(u_if.overflow), int'(m_overflow));
      chk("cmp_dup_drop", int'(u_if.dup_drop), int'(m_dup));
    end
  end

  task automatic cyc(input bit p, input int l, input bit po, input bit f);
    @(negedge clk);
    u_if.push     = p;
    u_if.push_lit = lit_t'(l);
    u_if.pop      = po;
    u_if.flush    = f;
    @(posedge clk);
    model_step(p, l, po, f);
    #1;
    u_if.push  = 1'b0;
    u_if.pop   = 1'b0;
    u_if.flush = 1'b0;
  endtask

  initial begin
    int r;
    checks        = 0;
    errors        = 0;
    cmp_en        = 1'b0;
    rst_n         = 1'b1;
    u_if.push     = 1'b0;
    u_if.push_lit = '0;
    u_if.pop      = 1'b0;
    u_if.flush    = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;

    chk("rst_empty",    int'(u_if.empty),    1);
    chk("rst_count",    int'(u_if.count),    0);
    chk("rst_pop_lit",  int'(u_if.pop_lit),  0);
    chk("rst_full",     int'(u_if.full),     0);
    chk("rst_conflict", int'(u_if.conflict), 0);

    // FIFO order
    cyc(1, 5, 0, 0);
    chk("first_push_vis", int'(u_if.pop_lit), 5);
    cyc(1, 7, 0, 0);
    cyc(1, -3, 0, 0);
    chk("order_count", int'(u_if.count), 3);
    chk("order_h0", int'(u_if.pop_lit), 5);
    cyc(0, 0, 1, 0);
    chk("order_h1", int'(u_if.pop_lit), 7);
    cyc(0, 0, 1, 0);
    chk("order_h2", int'(u_if.pop_lit), -3);
    cyc(0, 0, 1, 0);
    chk("order_empty", int'(u_if.empty), 1);
    chk("order_cnt0",  int'(u_if.count), 0);

    // duplicate drop
    cyc(1, 4, 0, 0);
    cyc(1, 4, 0, 0);
    chk("dup_pulse", int'(u_if.dup_drop), 1);
    chk("dup_count", int'(u_if.count), 1);
    cyc(0, 0, 0, 0);
    chk("dup_clear", int'(u_if.dup_drop), 0);
    cyc(0, 0, 0, 1);

    // contradiction
    cyc(1, 6, 0, 0);
    cyc(1, -6, 0, 0);
    chk("conf_set",   int'(u_if.conflict), 1);
    chk("conf_count", int'(u_if.count), 1);
    cyc(1, 9, 0, 0);
    chk("conf_drop_cnt", int'(u_if.count), 1);
    chk("conf_head",     int'(u_if.pop_lit), 6);
    cyc(0, 0, 0, 1);
    chk("flush_conf",  int'(u_if.conflict), 0);
    chk("flush_empty", int'(u_if.empty), 1);
    cyc(1, -6, 0, 0);
    chk("after_flush_head", int'(u_if.pop_lit), -6);
    cyc(0, 0, 0, 1);

    // fill, overflow, full push+pop, wrap
    for (int i = 1; i <= DEPTH; i++) cyc(1, i, 0, 0);
    chk("fill_full",  int'(u_if.full), 1);
    chk("model_fill", m_q.size(), DEPTH);
    cyc(1, 17, 0, 0);
    chk("ovf_set",   int'(u_if.overflow), 1);
    chk("ovf_count", int'(u_if.count), 16);
    cyc(1, 17, 1, 0);
    chk("fullpp_head",  int'(u_if.pop_lit), 2);
    chk("fullpp_count", int'(u_if.count), 16);
    for (int i = 2; i <= 17; i++) begin
      chk("wrap_order", int'(u_if.pop_lit), i);
      cyc(0, 0, 1, 0);
    end
    chk("wrap_empty", int'(u_if.empty), 1);
    cyc(0, 0, 0, 1);

    // contradiction against the slot popped in the same cycle
    cyc(1, 8, 0, 0);
    cyc(1, -8, 1, 0);
    chk("poppush_conf",  int'(u_if.conflict), 1);
    chk("poppush_empty", int'(u_if.empty), 1);
    cyc(0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      r = int'($urandom_range(0, 40)) - 20;
      if ($urandom_range(0, 30) == 0) r = -256;
      cyc(($urandom_range(0, 9) < 7), r, ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 49) == 0));
    end

    // asynchronous reset mid-fill
    cyc(0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(1, i * 3, 0, 0);
    cyc(1, 17, 0, 0);
    cyc(1, -17, 0, 0);
    #2 rst_n = 1'b1;
    model_reset();
    #1;
    chk("arst_count",    int'(u_if.count),    0);
    chk("arst_empty",    int'(u_if.empty),    1);
    chk("arst_pop_lit",  int'(u_if.pop_lit),  0);
    chk("arst_conflict", int'(u_if.conflict), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cyc(1, 3, 0, 0);
    chk("arst_first_push", int'(u_if.count), 1);
    chk("arst_first_head", int'(u_if.pop_lit), 3);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
